// File: rtl/ahb_slave_if_param.sv
// ahb_slave_if_param: AHB-side slave of the AHB2APB bridge that decodes, pipelines and returns read data.
// Define AHB_SLV_ERR_RESP_EN to add the two-cycle ERROR response for unmapped addresses.
module ahb_slave_if_param #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLV     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                REGION_BITS = 26
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              Hwrite,
  input  logic              Hreadyin,
  input  logic [1:0]        Htrans,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Prdata,
  output logic              valid,
  output logic [ADDR_W-1:0] Haddr1,
  output logic [ADDR_W-1:0] Haddr2,
  output logic [DATA_W-1:0] Hwdata1,
  output logic [DATA_W-1:0] Hwdata2,
  output logic              Hwritereg,
  output logic [NUM_SLV-1:0] tempselx,
  output logic [DATA_W-1:0] Hrdata,
  output logic [1:0]        Hresp,
  output logic              Hreadyout
);

  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              active;
  logic              err_idle;

  // The lower-bound test stops a wrapped subtraction from aliasing into the window.
  assign off      = Haddr - BASE_ADDR;
  assign idx      = off >> REGION_BITS;
  assign in_range = (Haddr >= BASE_ADDR) && (idx < ADDR_W'(NUM_SLV));
  assign active   = Hreadyin && (Htrans inside {TR_NONSEQ, TR_SEQ});
  assign valid    = active && in_range && err_idle;
  assign Hrdata   = Prdata;

  always_comb begin
    tempselx = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (in_range && (idx == ADDR_W'(i))) tempselx[i] = 1'b1;
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      Haddr1    <= '0;
      Haddr2    <= '0;
      Hwdata1   <= '0;
      Hwdata2   <= '0;
      Hwritereg <= 1'b0;
    end else if (Hreadyin) begin
      Haddr1    <= Haddr;
      Haddr2    <= Haddr1;
      Hwdata1   <= Hwdata;
      Hwdata2   <= Hwdata1;
      Hwritereg <= Hwrite;
    end
  end

`ifdef AHB_SLV_ERR_RESP_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_ERR1,
    S_ERR2
  } err_state_t;

  err_state_t err_state;

  // Transfers arriving during either ERROR cycle are ignored, so ERR2 always returns to IDLE.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      err_state <= S_IDLE;
      Hresp     <= 2'b00;
      Hreadyout <= 1'b1;
    end else begin
      case (err_state)
        S_IDLE: begin
          if (active && !in_range) begin
            err_state <= S_ERR1;
            Hresp     <= 2'b01;
            Hreadyout <= 1'b0;
          end
        end
        S_ERR1: begin
          err_state <= S_ERR2;
          Hresp     <= 2'b01;
          Hreadyout <= 1'b1;
        end
        default: begin
          err_state <= S_IDLE;
          Hresp     <= 2'b00;
          Hreadyout <= 1'b1;
        end
      endcase
    end
  end

  assign err_idle = (err_state == S_IDLE);
`else
  assign Hresp     = 2'b00;
  assign Hreadyout = 1'b1;
  assign err_idle  = 1'b1;
`endif

endmodule

// File: tb/tb_ahb_slave_if_param.sv
// tb_ahb_slave_if_param: vector table, corner-case sequences and random traffic for ahb_slave_if_param.
// Expectations follow AHB_SLV_ERR_RESP_EN the same way the design does.
`timescale 1ns/1ps
module tb_ahb_slave_if_param;

  localparam int          NUM_SLV     = 3;
  localparam int          REGION_BITS = 26;
  localparam logic [31:0] BASE_ADDR   = 32'h8000_0000;
`ifdef AHB_SLV_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

  logic               Hclk = 1'b0;
  logic               Hreset, Hwrite, Hreadyin;
  logic [1:0]         Htrans;
  logic [31:0]        Haddr, Hwdata, Prdata;
  logic               valid, Hwritereg, Hreadyout;
  logic [31:0]        Haddr1, Haddr2, Hwdata1, Hwdata2, Hrdata;
  logic [NUM_SLV-1:0] tempselx;
  logic [1:0]         Hresp;

  int checks   = 0;
  int failures = 0;

  // reference model: pipeline history and remaining ERROR-response cycles
  logic [31:0] mA1 = '0, mA2 = '0, mW1 = '0, mW2 = '0;
  logic        mWr = 1'b0;
  int          errLeft = 0;

  ahb_slave_if_param dut (
    .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
    .valid(valid), .Haddr1(Haddr1), .Haddr2(Haddr2), .Hwdata1(Hwdata1),
    .Hwdata2(Hwdata2), .Hwritereg(Hwritereg), .tempselx(tempselx),
    .Hrdata(Hrdata), .Hresp(Hresp), .Hreadyout(Hreadyout)
  );

  always #5 Hclk = ~Hclk;

  typedef struct {
    logic [1:0]         trans;
    logic               wr;
    logic               rdy;
    logic [31:0]        addr;
    logic [31:0]        prdata;
    logic               expValid;
    logic [NUM_SLV-1:0] expSel;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [NUM_SLV-1:0] refSel(input logic [31:0] a);
    longint unsigned slot;
    refSel = '0;
    if (a >= BASE_ADDR) begin
      slot = 64'(a - BASE_ADDR) / (64'd1 << REGION_BITS);
      if (slot < NUM_SLV) refSel[int'(slot)] = 1'b1;
    end
  endfunction

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [1:0] trans, input logic wr,
                               input logic rdy, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] prdata);
    Hreset   = rst;
    Htrans   = trans;
    Hwrite   = wr;
    Hreadyin = rdy;
    Haddr    = addr;
    Hwdata   = wdata;
    Prdata   = prdata;
  endtask

  task automatic checkOutput(input string name);
    logic [NUM_SLV-1:0] sel;
    logic               act;
    sel = refSel(Haddr);
    act = Hreadyin && Htrans[1];
    compare({name, ".valid"},     32'(valid),     32'(act && (sel != 0) && (errLeft == 0)));
    compare({name, ".tempselx"},  32'(tempselx),  32'(sel));
    compare({name, ".Hrdata"},    Hrdata,         Prdata);
    compare({name, ".Haddr1"},    Haddr1,         mA1);
    compare({name, ".Haddr2"},    Haddr2,         mA2);
    compare({name, ".Hwdata1"},   Hwdata1,        mW1);
    compare({name, ".Hwdata2"},   Hwdata2,        mW2);
    compare({name, ".Hwritereg"}, 32'(Hwritereg), 32'(mWr));
    compare({name, ".Hresp"},     32'(Hresp),     (errLeft > 0) ? 32'd1 : 32'd0);
    compare({name, ".Hreadyout"}, 32'(Hreadyout), (errLeft == 2) ? 32'd0 : 32'd1);
  endtask

  task automatic updateModel();
    logic unmappedActive;
    unmappedActive = Hreadyin && Htrans[1] && (refSel(Haddr) == 0);
    if (Hreset) begin
      mA1 = '0; mA2 = '0; mW1 = '0; mW2 = '0; mWr = 1'b0;
      errLeft = 0;
    end else begin
      if (errLeft > 0) errLeft--;
      else if (ERR_EN && unmappedActive) errLeft = 2;
      if (Hreadyin) begin
        mA2 = mA1; mA1 = Haddr;
        mW2 = mW1; mW1 = Hwdata;
        mWr = Hwrite;
      end
    end
  endtask

  task automatic clockEdge();
    @(posedge Hclk);
    updateModel();
    #1;
  endtask

  task automatic runCycle(input string name);
    #1;
    checkOutput(name);
    clockEdge();
  endtask

  task automatic drainIdle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, IDLE, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
      runCycle("drain");
    end
  endtask

  initial begin
    vecs[0]  = '{NONSEQ, 1'b1, 1'b1, 32'h8000_0001, 32'h1111_1111, 1'b1, 3'b001};
    vecs[1]  = '{NONSEQ, 1'b0, 1'b1, 32'h8400_0002, 32'hCAFE_BABE, 1'b1, 3'b010};
    vecs[2]  = '{SEQ,    1'b0, 1'b1, 32'h8BFF_FFFF, 32'h2222_2222, 1'b1, 3'b100};
    vecs[3]  = '{NONSEQ, 1'b0, 1'b1, 32'h8C00_0000, 32'h3333_3333, 1'b0, 3'b000};
    vecs[4]  = '{NONSEQ, 1'b1, 1'b1, 32'h7FFF_FFFC, 32'h4444_4444, 1'b0, 3'b000};
    vecs[5]  = '{BUSY,   1'b1, 1'b1, 32'h8000_0000, 32'h5555_5555, 1'b0, 3'b001};
    vecs[6]  = '{IDLE,   1'b0, 1'b1, 32'h8800_0000, 32'h6666_6666, 1'b0, 3'b100};
    vecs[7]  = '{NONSEQ, 1'b0, 1'b0, 32'h8000_0000, 32'h7777_7777, 1'b0, 3'b001};
    vecs[8]  = '{SEQ,    1'b1, 1'b1, 32'h87FF_FFFF, 32'h8888_8888, 1'b1, 3'b010};
    vecs[9]  = '{NONSEQ, 1'b0, 1'b1, 32'h0000_0000, 32'h9999_9999, 1'b0, 3'b000};
    vecs[10] = '{SEQ,    1'b0, 1'b1, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 1'b0, 3'b000};

    // reset held for three clocks with random inputs
    applyStimulus(1'b1, 2'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
    clockEdge();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 2'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
      #1;
      compare("reset.Haddr1", Haddr1, 32'h0);
      compare("reset.Hwdata2", Hwdata2, 32'h0);
      compare("reset.Hresp", 32'(Hresp), 32'd0);
      compare("reset.Hreadyout", 32'(Hreadyout), 32'd1);
      checkOutput("reset");
      clockEdge();
    end
    drainIdle();

    // decode table
    for (int v = 0; v < 11; v++) begin
      applyStimulus(1'b0, vecs[v].trans, vecs[v].wr, vecs[v].rdy, vecs[v].addr,
                    32'h0, vecs[v].prdata);
      #1;
      compare($sformatf("vec%0d.valid", v), 32'(valid), 32'(vecs[v].expValid));
      compare($sformatf("vec%0d.tempselx", v), 32'(tempselx), 32'(vecs[v].expSel));
      compare($sformatf("vec%0d.Hrdata", v), Hrdata, vecs[v].prdata);
      checkOutput($sformatf("vec%0d", v));
      clockEdge();
      drainIdle();
    end

    // write pipeline latency
    applyStimulus(1'b0, NONSEQ, 1'b1, 1'b1, 32'h8000_0001, 32'hDEAD_BEEF, 32'h0);
    #1;
    compare("wr.valid", 32'(valid), 32'd1);
    compare("wr.tempselx", 32'(tempselx), 32'd1);
    checkOutput("wr");
    clockEdge();
    applyStimulus(1'b0, IDLE, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF, 32'h0);
    #1;
    compare("wr.Haddr1", Haddr1, 32'h8000_0001);
    compare("wr.Hwritereg", 32'(Hwritereg), 32'd1);
    checkOutput("wr1");
    clockEdge();
    applyStimulus(1'b0, IDLE, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    #1;
    compare("wr.Hwdata2", Hwdata2, 32'hDEAD_BEEF);
    compare("wr.Haddr2", Haddr2, 32'h8000_0001);
    checkOutput("wr2");
    clockEdge();
    drainIdle();

    // ERROR response; a transfer in the second ERROR cycle is dropped
    for (int r = 0; r < 2; r++) begin
      applyStimulus(1'b0, NONSEQ, 1'b0, 1'b1, 32'h9000_0000, 32'h0, 32'h0);
      runCycle("err0");
      applyStimulus(1'b0, IDLE, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
      #1;
      compare("err1.Hresp", 32'(Hresp), ERR_EN ? 32'd1 : 32'd0);
      compare("err1.Hreadyout", 32'(Hreadyout), ERR_EN ? 32'd0 : 32'd1);
      checkOutput("err1");
      clockEdge();
      applyStimulus(1'b0, NONSEQ, 1'b0, 1'b1, (r == 0) ? 32'h8000_0000 : 32'h9000_0000,
                    32'h0, 32'h0);
      #1;
      compare("err2.Hresp", 32'(Hresp), ERR_EN ? 32'd1 : 32'd0);
      compare("err2.Hreadyout", 32'(Hreadyout), 32'd1);
      compare("err2.valid", 32'(valid), (!ERR_EN && r == 0) ? 32'd1 : 32'd0);
      checkOutput("err2");
      clockEdge();
      applyStimulus(1'b0, IDLE, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
      #1;
      compare("err3.Hresp", 32'(Hresp), 32'd0);
      compare("err3.Hreadyout", 32'(Hreadyout), 32'd1);
      checkOutput("err3");
      clockEdge();
      drainIdle();
    end

    // stall holds the address pipeline
    applyStimulus(1'b0, NONSEQ, 1'b0, 1'b1, 32'h8000_0010, 32'h0, 32'h0);
    runCycle("stall0");
    applyStimulus(1'b0, SEQ, 1'b0, 1'b1, 32'h8000_0020, 32'h0, 32'h0);
    runCycle("stall1");
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, NONSEQ, 1'b1, 1'b0, 32'h8400_0000, 32'h1234_5678, 32'h0);
      runCycle("stall");
    end
    #1;
    compare("stall.Haddr1", Haddr1, 32'h8000_0020);
    compare("stall.Haddr2", Haddr2, 32'h8000_0010);
    drainIdle();

    // reset during the first ERROR cycle
    applyStimulus(1'b0, NONSEQ, 1'b1, 1'b1, 32'h9000_0000, 32'h0, 32'h0);
    runCycle("rsterr0");
    applyStimulus(1'b1, IDLE, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    runCycle("rsterr1");
    applyStimulus(1'b0, IDLE, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    #1;
    compare("rsterr.Hresp", 32'(Hresp), 32'd0);
    compare("rsterr.Hreadyout", 32'(Hreadyout), 32'd1);
    compare("rsterr.Haddr1", Haddr1, 32'h0);
    checkOutput("rsterr2");
    clockEdge();

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] addr;
      logic [31:0] edges [8];
      edges = '{32'h8BFF_FFFF, 32'h8C00_0000, 32'h7FFF_FFFF, 32'h8000_0000,
                32'h83FF_FFFF, 32'h8400_0000, 32'h87FF_FFFF, 32'h8800_0000};
      case ($urandom_range(0, 4))
        0, 1:    addr = BASE_ADDR + ($urandom % 32'h0C00_0000);
        2:       addr = edges[$urandom_range(0, 7)];
        3:       addr = $urandom & 32'h7FFF_FFFF;
        default: addr = $urandom;
      endcase
      applyStimulus(($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)), 1'($urandom),
                    ($urandom_range(0, 7) != 0), addr, $urandom, $urandom);
      runCycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
